// File: rtl/io_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_bus_pkg : shared types and constants for the I/O bus target      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package io_bus_pkg;

  typedef enum logic [1:0] {
    REG_RAM = 2'b00,
    REG_LED = 2'b01,
    REG_SW  = 2'b10,
    REG_TMR = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    T_IDLE    = 2'b00,
    T_RUN     = 2'b01,
    T_EXPIRED = 2'b10
  } tstate_e;

  localparam logic [1:0] TMR_LOAD   = 2'd0;
  localparam logic [1:0] TMR_COUNT  = 2'd1;
  localparam logic [1:0] TMR_CTRL   = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;

  function automatic region_e region_of(input logic [1:0] i_hi);
    return region_e'(i_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_timer : prescaled countdown timer with sticky expiry flag        |
// | Option: IO_BUS_TARGET_AUTORELOAD_EN selects periodic reload.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module io_timer #(
  parameter int DATA_W   = 9,
  parameter int PRESCALE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_we,
  input  logic              i_ctrl_we,
  input  logic              i_status_rd,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load,
  output logic [DATA_W-1:0] o_count,
  output logic [1:0]        o_ctrl,
  output logic              o_expired
);
  import io_bus_pkg::*;

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  tstate_e           r_state, w_state_n;
  logic [DATA_W-1:0] r_load, r_count, w_count_n;
  logic [PW-1:0]     r_pre, w_pre_n;
  logic [1:0]        r_ctrl;
  logic              r_exp, w_set;
  logic              w_start, w_stop;

  // STOP dominates: a write carrying both bits behaves as a plain STOP
  assign w_stop  = i_ctrl_we & i_wdata[CTRL_STOP];
  assign w_start = i_ctrl_we & i_wdata[CTRL_START] & ~i_wdata[CTRL_STOP];

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_pre_n   = r_pre;
    w_set     = 1'b0;
    if (w_stop) begin
      w_state_n = T_IDLE;
      w_pre_n   = '0;
    end else if (w_start) begin
      w_count_n = r_load;
      w_pre_n   = '0;
      if (r_load == '0) begin
        w_state_n = T_EXPIRED;
        w_set     = 1'b1;
      end else begin
        w_state_n = T_RUN;
      end
    end else if (r_state == T_RUN) begin
      if (r_pre == PS_LAST) begin
        w_pre_n = '0;
        if (r_count <= DATA_W'(1)) begin
          w_set = 1'b1;
`ifdef IO_BUS_TARGET_AUTORELOAD_EN
          w_count_n = r_load;
`else
          w_count_n = '0;
          w_state_n = T_EXPIRED;
`endif
        end else begin
          w_count_n = r_count - DATA_W'(1);
        end
      end else begin
        w_pre_n = r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= T_IDLE;
      r_load  <= '0;
      r_count <= '0;
      r_pre   <= '0;
      r_ctrl  <= '0;
      r_exp   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_pre   <= w_pre_n;
      if (i_load_we) r_load <= i_wdata;
      if (i_ctrl_we) r_ctrl <= i_wdata[1:0];
      if (w_set)                         r_exp <= 1'b1;
      else if (i_status_rd || w_start)   r_exp <= 1'b0;
    end
  end

  assign o_load    = r_load;
  assign o_count   = r_count;
  assign o_ctrl    = r_ctrl;
  assign o_expired = r_exp;

endmodule
`default_nettype wire

// File: rtl/io_bus_target.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | io_bus_target : memory-bus responder for LEDs, switches and timer   |
// | Option: IO_BUS_TARGET_AUTORELOAD_EN (periodic timer).  Rev 1.0      |
// +--------------------------------------------------------------------+
module io_bus_target #(
  parameter int DATA_W   = 9,
  parameter int PRESCALE = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DOUT,
  input  logic              W,
  input  logic [DATA_W-1:0] RAM_Q,
  output logic              RAM_WE,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] LEDS,
  output logic              TDONE
);
  import io_bus_pkg::*;

  region_e           w_region, r_addr_q;
  logic [1:0]        w_off;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_leds, r_sw1, r_sw2, r_io_rdata, w_io_rdata;
  logic [DATA_W-1:0] w_tmr_load, w_tmr_count;
  logic [1:0]        w_tmr_ctrl;
  logic              w_tmr_exp, w_is_tmr;
  logic              w_unused_addr;

  assign w_region      = region_of(ADDR[DATA_W-1 -: 2]);
  assign w_off         = ADDR[1:0];
  assign w_is_tmr      = (w_region == REG_TMR);
  assign w_unused_addr = &{1'b0, ADDR[DATA_W-3:2]};

  assign RAM_WE = W & (w_region == REG_RAM);

  io_timer #(
    .DATA_W   (DATA_W),
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk         (CLK),
    .rst         (RST),
    .i_load_we   (W & w_is_tmr & (w_off == TMR_LOAD)),
    .i_ctrl_we   (W & w_is_tmr & (w_off == TMR_CTRL)),
    .i_status_rd (w_is_tmr & (w_off == TMR_STATUS)),
    .i_wdata     (DOUT),
    .o_load      (w_tmr_load),
    .o_count     (w_tmr_count),
    .o_ctrl      (w_tmr_ctrl),
    .o_expired   (w_tmr_exp)
  );

  always_comb begin
    w_io_rdata = '0;
    case (w_region)
      REG_LED: w_io_rdata = r_leds;
      REG_SW:  w_io_rdata = r_sw2;
      REG_TMR: begin
        case (w_off)
          TMR_LOAD:  w_io_rdata = w_tmr_load;
          TMR_COUNT: w_io_rdata = w_tmr_count;
          TMR_CTRL:  w_io_rdata = {{(DATA_W-2){1'b0}}, w_tmr_ctrl};
          default:   w_io_rdata = {{(DATA_W-1){1'b0}}, w_tmr_exp};
        endcase
      end
      default: w_io_rdata = '0;
    endcase
  end

  // r_rd_valid keeps DIN at zero until the first post-reset bus cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr_q   <= REG_RAM;
      r_rd_valid <= 1'b0;
      r_io_rdata <= '0;
      r_leds     <= '0;
      r_sw1      <= '0;
      r_sw2      <= '0;
    end else begin
      r_addr_q   <= w_region;
      r_rd_valid <= 1'b1;
      r_io_rdata <= w_io_rdata;
      r_sw1      <= SW;
      r_sw2      <= r_sw1;
      if (W && (w_region == REG_LED)) r_leds <= DOUT;
    end
  end

  assign DIN   = (r_rd_valid && (r_addr_q == REG_RAM)) ? RAM_Q : r_io_rdata;
  assign LEDS  = r_leds;
  assign TDONE = w_tmr_exp;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_target.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_io_bus_target : directed + random checks against a cycle model   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_io_bus_target;

  localparam int PS = 16;
`ifdef IO_BUS_TARGET_AUTORELOAD_EN
  localparam int LMIN = 1;
`else
  localparam int LMIN = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST, W, RAM_WE, TDONE;
  logic [8:0] ADDR, DOUT, RAM_Q, SW, DIN, LEDS;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  logic [8:0] m_leds, m_load, m_cnt, m_sw1, m_sw2, m_io;
  logic [1:0] m_ctrl;
  bit         m_run, m_exp, m_valid, m_ram_sel;
  int         m_rem;

  always #5 CLK = ~CLK;

  io_bus_target #(.DATA_W(9), .PRESCALE(PS)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DOUT(DOUT), .W(W), .RAM_Q(RAM_Q),
    .RAM_WE(RAM_WE), .DIN(DIN), .SW(SW), .LEDS(LEDS), .TDONE(TDONE)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // remaining cycles to expiry expressed as whole timer ticks
  function automatic logic [8:0] m_count();
    if (m_run) return 9'((m_rem + PS - 1) / PS);
    return m_cnt;
  endfunction

  task automatic model();
    logic [1:0] rg, off;
    bit start, stop, set;
    rg  = ADDR[8:7];
    off = ADDR[1:0];
    if (RST) begin
      m_leds = '0; m_load = '0; m_cnt = '0; m_sw1 = '0; m_sw2 = '0; m_io = '0;
      m_ctrl = '0; m_run = 0; m_exp = 0; m_valid = 0; m_ram_sel = 0; m_rem = 0;
      return;
    end
    m_valid   = 1;
    m_ram_sel = (rg == 2'd0);
    case (rg)
      2'd1: m_io = m_leds;
      2'd2: m_io = m_sw2;
      2'd3: case (off)
              2'd0: m_io = m_load;
              2'd1: m_io = m_count();
              2'd2: m_io = {7'd0, m_ctrl};
              default: m_io = {8'd0, m_exp};
            endcase
      default: m_io = '0;
    endcase
    stop  = W && rg == 2'd3 && off == 2'd2 && DOUT[1];
    start = W && rg == 2'd3 && off == 2'd2 && DOUT[0] && !DOUT[1];
    set   = 0;
    if (stop) begin
      if (m_run) m_cnt = m_count();
      m_run = 0;
    end else if (start) begin
      if (m_load == 0) begin m_run = 0; m_cnt = 0; set = 1; end
      else begin m_run = 1; m_rem = m_load * PS; end
    end else if (m_run) begin
      m_rem--;
      if (m_rem == 0) begin
        set = 1;
`ifdef IO_BUS_TARGET_AUTORELOAD_EN
        m_rem = m_load * PS;
`else
        m_run = 0; m_cnt = 0;
`endif
      end
    end
    if (set) m_exp = 1;
    else if (start || (rg == 2'd3 && off == 2'd3)) m_exp = 0;
    m_sw2 = m_sw1;
    m_sw1 = SW;
    if (W && rg == 2'd1) m_leds = DOUT;
    if (W && rg == 2'd3 && off == 2'd0) m_load = DOUT;
    if (W && rg == 2'd3 && off == 2'd2) m_ctrl = DOUT[1:0];
  endtask

  task automatic drive(input logic [8:0] a, input logic [8:0] d, input logic w);
    ADDR = a; DOUT = d; W = w; RAM_Q = 9'($urandom);
  endtask

  task automatic step();
    @(negedge CLK);
    chk("ramwe", {8'd0, RAM_WE}, {8'd0, (W && ADDR[8:7] == 2'b00)});
    chk("din", DIN, (m_valid && m_ram_sel) ? RAM_Q : m_io);
    chk("leds", LEDS, m_leds);
    chk("tdone", {8'd0, TDONE}, {8'd0, m_exp});
    @(posedge CLK);
    model();
    #1;
  endtask

  initial begin
    int k;
    logic [1:0] rgn, off;
    logic [8:0] a, d;
    int r;

    RST = 1'b1; SW = '0;
    drive(9'h000, 9'h000, 1'b0);
    @(posedge CLK); model(); #1;
    step();
    chk("rst_leds", LEDS, 9'h000);
    chk("rst_din", DIN, 9'h000);
    chk("rst_tdone", {8'd0, TDONE}, 9'h000);
    RST = 1'b0;

    drive(9'h080, 9'h0AA, 1'b1); step();
    chk("led_wr", LEDS, 9'h0AA);
    drive(9'h080, 9'h000, 1'b0); step();
    chk("led_rd", DIN, 9'h0AA);

    SW = 9'h155;
    drive(9'h000, 9'h000, 1'b0); step(); step(); step();
    drive(9'h100, 9'h000, 1'b0); step();
    chk("sw_rd", DIN, 9'h155);
    drive(9'h100, 9'h1FF, 1'b1); #1;
    chk("ramwe_sw", {8'd0, RAM_WE}, 9'h000);
    step();
    chk("sw_wr_ign", LEDS, 9'h0AA);
    drive(9'h07F, 9'h011, 1'b1); #1;
    chk("ramwe_hi", {8'd0, RAM_WE}, 9'h001);
    step();
    drive(9'h005, 9'h000, 1'b0); step();
    RAM_Q = 9'h123; #1;
    chk("ram_rd", DIN, 9'h123);

    // one-shot latency: LOAD=3 gives 3*PS cycles
    drive(9'h180, 9'd3, 1'b1); step();
    drive(9'h182, 9'd1, 1'b1); step();
    drive(9'h000, 9'h000, 1'b0);
    k = 0;
    while (!TDONE && k < 200) begin step(); k++; end
    chk("tdone_lat", 9'(k), 9'd48);
    drive(9'h183, 9'h000, 1'b0); step();
    chk("status_rd", DIN, 9'h001);
    drive(9'h000, 9'h000, 1'b0); step();
    chk("tdone_clr", {8'd0, TDONE}, 9'h000);

    drive(9'h180, 9'd0, 1'b1); step();
    drive(9'h182, 9'd1, 1'b1); step();
    chk("load0_exp", {8'd0, TDONE}, 9'h001);

    // STOP+START together must stop and freeze COUNT at 4
    drive(9'h180, 9'd5, 1'b1); step();
    drive(9'h182, 9'd1, 1'b1); step();
    drive(9'h000, 9'h000, 1'b0);
    for (int i = 0; i < 20; i++) step();
    drive(9'h182, 9'd3, 1'b1); step();
    drive(9'h000, 9'h000, 1'b0);
    for (int i = 0; i < 40; i++) step();
    drive(9'h181, 9'h000, 1'b0); step();
    chk("stop_cnt", DIN, 9'd4);

    drive(9'h180, 9'd4, 1'b1); step();
    drive(9'h182, 9'd1, 1'b1); step();
    drive(9'h000, 9'h000, 1'b0);
    for (int i = 0; i < 30; i++) step();
    RST = 1'b1; step(); RST = 1'b0;
    chk("rst_mid_leds", LEDS, 9'h000);
    drive(9'h181, 9'h000, 1'b0); step();
    chk("rst_mid_cnt", DIN, 9'h000);
    drive(9'h000, 9'h000, 1'b0);
    for (int i = 0; i < 60; i++) step();
    chk("rst_mid_tdone", {8'd0, TDONE}, 9'h000);

`ifdef IO_BUS_TARGET_AUTORELOAD_EN
    drive(9'h180, 9'd2, 1'b1); step();
    drive(9'h182, 9'd1, 1'b1); step();
    drive(9'h000, 9'h000, 1'b0);
    k = 0;
    while (!TDONE && k < 200) begin step(); k++; end
    chk("arl_first", 9'(k), 9'd32);
    drive(9'h183, 9'h000, 1'b0); step();
    drive(9'h000, 9'h000, 1'b0);
    k = 1;
    while (!TDONE && k < 200) begin step(); k++; end
    chk("arl_period", 9'(k), 9'd32);
    drive(9'h182, 9'd2, 1'b1); step();
`endif

    for (int i = 0; i < 1500; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      r   = $urandom_range(0, 99);
      rgn = (r < 40) ? 2'd0 : (r < 60) ? 2'd1 : (r < 75) ? 2'd2 : 2'd3;
      off = 2'($urandom_range(0, 3));
      a   = {rgn, 5'($urandom), off};
      d   = 9'($urandom);
      if (rgn == 2'd3 && off == 2'd0) d = 9'($urandom_range(LMIN, 3));
      if (rgn == 2'd3 && off == 2'd2) d = 9'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) SW = 9'($urandom);
      drive(a, d, 1'($urandom_range(0, 1)));
      step();
    end
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
